// File: rtl/pac_defs.sv
// Shared constants for the Pac-Man sprite animator: headings, life-cycle states,
// mouth steps and bitmap selector kinds.
package pac_defs;

    localparam logic [3:0] DIR_L = 4'b1000;
    localparam logic [3:0] DIR_U = 4'b0100;
    localparam logic [3:0] DIR_R = 4'b0010;
    localparam logic [3:0] DIR_D = 4'b0001;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'b00,
        ST_DYING = 2'b01,
        ST_DEAD  = 2'b10
    } pac_state_e;

    localparam logic [1:0] STEP_CLOSED = 2'd0;
    localparam logic [1:0] STEP_HALF_A = 2'd1;
    localparam logic [1:0] STEP_OPEN   = 2'd2;
    localparam logic [1:0] STEP_HALF_B = 2'd3;

    typedef enum logic [1:0] {
        SEL_DEFAULT = 2'd0,
        SEL_HALF    = 2'd1,
        SEL_OPEN    = 2'd2,
        SEL_DEATH   = 2'd3
    } sel_kind_e;

    function automatic logic is_onehot4(input logic [3:0] d);
        return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/pac_sprite_rom.sv
// Combinational sprite texel lookup: round body minus a mouth wedge (heading-aligned)
// or a death wedge that widens from the top with each death frame.
module pac_sprite_rom
    import pac_defs::*;
#(
    parameter int SPR_W        = 12,
    parameter int SPR_H        = 12,
    parameter int RC_W         = 4,
    parameter int DEATH_FRAMES = 8
) (
    input  sel_kind_e        sel_kind_i,
    input  logic [3:0]       heading_i,
    input  logic [2:0]       frame_i,
    input  logic [RC_W-1:0]  row_i,
    input  logic [RC_W-1:0]  col_i,
    output logic             bit_o
);

    localparam int RAD = ((SPR_W < SPR_H) ? SPR_W : SPR_H) - 1;

    // Coordinates are doubled so the sprite centre lands on an integer.
    int   dx, dy, adx, ady, fwd, lat;
    logic body, cut;

    always_comb begin
        dx   = 2 * int'(col_i) - (SPR_W - 1);
        dy   = 2 * int'(row_i) - (SPR_H - 1);
        adx  = (dx < 0) ? -dx : dx;
        ady  = (dy < 0) ? -dy : dy;
        body = (dx * dx + dy * dy) <= (RAD * RAD);

        case (heading_i)
            DIR_L:   begin fwd = -dx; lat = ady; end
            DIR_U:   begin fwd = -dy; lat = adx; end
            DIR_D:   begin fwd = dy;  lat = adx; end
            default: begin fwd = dx;  lat = ady; end
        endcase

        case (sel_kind_i)
            SEL_HALF:  cut = (fwd > 0) && (2 * lat <= fwd);
            SEL_OPEN:  cut = (fwd > 0) && (lat <= fwd);
            SEL_DEATH: cut = (dy <= 0) && (adx * (DEATH_FRAMES - 1) <= int'(frame_i) * (-dy));
            default:   cut = 1'b0;
        endcase

        bit_o = body && !cut && (int'(col_i) < SPR_W) && (int'(row_i) < SPR_H);
    end

endmodule

// File: rtl/pac_sprite_animator.sv
// Pac-Man sprite pixel generator: animation tick, heading latch, life-cycle FSM and a
// two-stage registered pixel pipeline feeding the colour mux.
module pac_sprite_animator
    import pac_defs::*;
#(
    parameter int SPR_W        = 12,
    parameter int SPR_H        = 12,
    parameter int SCALE_LOG2   = 1,
    parameter int COORD_W      = 5,
    parameter int ANIM_PERIOD  = 10000000,
    parameter int CNT_W        = 24,
    parameter int DEATH_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               in_valid,
    input  logic [3:0]         direction,
    input  logic               moving,
    input  logic               die,
    input  logic               respawn,
    output logic               pixel,
    output logic               pix_valid,
    output logic [2:0]         frame_idx,
    output logic [1:0]         state,
    output logic               die_done
);

    localparam int               RC_W       = COORD_W - SCALE_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ANIM_PERIOD - 1);
    localparam logic [2:0]       DEATH_LAST = 3'(DEATH_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [3:0]       head_q;
    pac_state_e       state_q, state_d;
    logic [2:0]       frame_q, frame_d;
    logic             die_done_q, die_done_d;
    logic             accept;

    logic [RC_W-1:0]  col_s, row_s, col1_q, row1_q;
    logic             inr_s, inr1_q, v1_q, dead1_q;
    sel_kind_e        kind_s, kind1_q;
    logic [3:0]       head1_q;
    logic [2:0]       frame1_q;
    logic             rom_bit, pixel_q, pixel_d, pv_q;
    logic             unused_lsbs;

    assign unused_lsbs = ^{x, y};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            head_q     <= DIR_R;
            state_q    <= ST_ALIVE;
            frame_q    <= 3'd0;
            die_done_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            state_q    <= state_d;
            frame_q    <= frame_d;
            die_done_q <= die_done_d;
            if (is_onehot4(direction)) begin
                head_q <= direction;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        die_done_d = 1'b0;
        accept     = 1'b0;
        case (state_q)
            ST_ALIVE: begin
                if (die) begin
                    state_d = ST_DYING;
                    frame_d = 3'd0;
                    accept  = 1'b1;
                end else if (tick_q && moving) begin
                    frame_d = {1'b0, frame_q[1:0] + 2'd1};
                end
            end
            ST_DYING: begin
                if (tick_q) begin
                    if (frame_q == DEATH_LAST) begin
                        state_d    = ST_DEAD;
                        frame_d    = 3'd0;
                        die_done_d = 1'b1;
                    end else begin
                        frame_d = frame_q + 3'd1;
                    end
                end
            end
            ST_DEAD: begin
                if (respawn) begin
                    state_d = ST_ALIVE;
                    frame_d = 3'd0;
                    accept  = 1'b1;
                end
            end
            default: begin
                state_d = ST_ALIVE;
                frame_d = 3'd0;
            end
        endcase

        // A fresh life or death sequence starts with a full tick period.
        if (accept) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + 1'b1;
            tick_d = 1'b0;
        end
    end

    assign col_s = RC_W'(x >> SCALE_LOG2);
    assign row_s = RC_W'(y >> SCALE_LOG2);
    assign inr_s = (int'(col_s) < SPR_W) && (int'(row_s) < SPR_H);

    always_comb begin
        kind_s = SEL_DEFAULT;
        if (state_q == ST_DYING) begin
            kind_s = SEL_DEATH;
        end else begin
            case (frame_q[1:0])
                STEP_OPEN:                kind_s = SEL_OPEN;
                STEP_HALF_A, STEP_HALF_B: kind_s = SEL_HALF;
                default:                  kind_s = SEL_DEFAULT;
            endcase
        end
    end

    // Bitmap selection is frozen in S1 so a tick during flight cannot mix frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col1_q   <= '0;
            row1_q   <= '0;
            inr1_q   <= 1'b0;
            v1_q     <= 1'b0;
            dead1_q  <= 1'b0;
            kind1_q  <= SEL_DEFAULT;
            head1_q  <= DIR_R;
            frame1_q <= 3'd0;
            pixel_q  <= 1'b0;
            pv_q     <= 1'b0;
        end else begin
            col1_q   <= col_s;
            row1_q   <= row_s;
            inr1_q   <= inr_s;
            v1_q     <= in_valid;
            dead1_q  <= (state_q == ST_DEAD);
            kind1_q  <= kind_s;
            head1_q  <= head_q;
            frame1_q <= frame_q;
            pixel_q  <= pixel_d;
            pv_q     <= v1_q;
        end
    end

    pac_sprite_rom #(
        .SPR_W        (SPR_W),
        .SPR_H        (SPR_H),
        .RC_W         (RC_W),
        .DEATH_FRAMES (DEATH_FRAMES)
    ) u_rom (
        .sel_kind_i (kind1_q),
        .heading_i  (head1_q),
        .frame_i    (frame1_q),
        .row_i      (row1_q),
        .col_i      (col1_q),
        .bit_o      (rom_bit)
    );

    assign pixel_d   = v1_q && inr1_q && !dead1_q && rom_bit;

    assign pixel     = pixel_q;
    assign pix_valid = pv_q;
    assign frame_idx = frame_q;
    assign state     = state_q;
    assign die_done  = die_done_q;

endmodule

// File: tb/tb_pac_sprite_animator.sv
// Directed bench for pac_sprite_animator with ANIM_PERIOD=4: a table of frozen-frame
// row scans against hand-derived bitmap rows plus sequences for timing and death.
module tb_pac_sprite_animator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] x, y;
    logic       in_valid;
    logic [3:0] direction;
    logic       moving, die, respawn;
    logic       pixel, pix_valid, die_done;
    logic [2:0] frame_idx;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  step;
        logic [3:0]  dir;
        logic [4:0]  yv;
        logic [11:0] row_exp;
        string       name;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    pac_sprite_animator #(.ANIM_PERIOD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .in_valid  (in_valid),
        .direction (direction),
        .moving    (moving),
        .die       (die),
        .respawn   (respawn),
        .pixel     (pixel),
        .pix_valid (pix_valid),
        .frame_idx (frame_idx),
        .state     (state),
        .die_done  (die_done)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] expand(input logic [11:0] r);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < 24; j++) v[j] = r[j/2];
        return v;
    endfunction

    task automatic go_step(input logic [1:0] st, input logic [3:0] dir, input string nm);
        int n;
        moving    = 1'b0;
        direction = dir;
        cyc();
        if (frame_idx != {1'b0, st}) begin
            moving = 1'b1;
            n = 0;
            while (frame_idx != {1'b0, st} && n < 40) begin
                cyc();
                n++;
            end
            moving = 1'b0;
            if (n >= 40) begin
                total++;
                bad++;
                $display("FAIL %s_reach_step: got=%0d expected=%0d", nm, frame_idx, st);
            end
        end
    endtask

    task automatic scan_check(input string nm, input logic [4:0] yv, input logic [11:0] row_exp);
        logic [31:0] pix_v, val_v;
        pix_v = '0;
        val_v = '0;
        for (int i = 0; i < 34; i++) begin
            if (i >= 2) begin
                pix_v[i-2] = pixel;
                val_v[i-2] = pix_valid;
            end
            if (i < 32) begin
                x        = 5'(i);
                y        = yv;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            cyc();
        end
        in_valid = 1'b0;
        check({nm, "_pix"}, pix_v, expand(row_exp));
        check({nm, "_valid"}, val_v, 32'hFFFF_FFFF);
        check({nm, "_tail"}, {31'b0, pix_valid}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int holdbad, dying, prev, order_bad, dd_early;
        bit done;

        vecs[0]  = '{2'd0, 4'b0010, 5'd10, 12'h7FE, "closed_r_row5"};
        vecs[1]  = '{2'd1, 4'b0010, 5'd10, 12'h07E, "half_r_row5"};
        vecs[2]  = '{2'd2, 4'b0010, 5'd10, 12'h03E, "open_r_row5"};
        vecs[3]  = '{2'd3, 4'b0010, 5'd10, 12'h07E, "half2_r_row5"};
        vecs[4]  = '{2'd2, 4'b1000, 5'd10, 12'h7C0, "open_l_row5"};
        vecs[5]  = '{2'd1, 4'b1000, 5'd10, 12'h7E0, "half_l_row5"};
        vecs[6]  = '{2'd2, 4'b0100, 5'd10, 12'h79E, "open_u_row5"};
        vecs[7]  = '{2'd2, 4'b0001, 5'd10, 12'h7FE, "open_d_row5"};
        vecs[8]  = '{2'd0, 4'b0001, 5'd2,  12'h1F8, "closed_row1"};
        vecs[9]  = '{2'd0, 4'b1000, 5'd0,  12'h000, "closed_row0"};
        vecs[10] = '{2'd2, 4'b0010, 5'd24, 12'h000, "row12_out"};

        rst_n = 1'b0; x = '0; y = '0; in_valid = 1'b0;
        direction = 4'b1000; moving = 1'b1; die = 1'b0; respawn = 1'b0;
        repeat (3) cyc();
        check("reset_state", {30'b0, state}, 32'd0);
        check("reset_frame", {29'b0, frame_idx}, 32'd0);
        check("reset_pix", {29'b0, pixel, pix_valid, die_done}, 32'd0);

        // Release just after an edge; edge k below is the k-th edge after release.
        rst_n = 1'b1;
        repeat (4) cyc();
        check("frame_k4", {29'b0, frame_idx}, 32'd0);
        cyc();
        check("frame_k5", {29'b0, frame_idx}, 32'd1);
        repeat (4) cyc();
        check("frame_k9", {29'b0, frame_idx}, 32'd2);
        moving  = 1'b0;
        holdbad = 0;
        for (int i = 0; i < 24; i++) begin
            cyc();
            if (frame_idx != 3'd2) holdbad++;
        end
        check("freeze_hold", 32'(holdbad), 32'd0);
        moving = 1'b1;
        repeat (3) cyc();
        check("frame_k36", {29'b0, frame_idx}, 32'd2);
        cyc();
        check("frame_k37", {29'b0, frame_idx}, 32'd3);
        repeat (4) cyc();
        check("frame_k41_wrap", {29'b0, frame_idx}, 32'd0);

        for (int v = 0; v < 11; v++) begin
            go_step(vecs[v].step, vecs[v].dir, vecs[v].name);
            scan_check(vecs[v].name, vecs[v].yv, vecs[v].row_exp);
        end

        moving = 1'b0;
        direction = 4'b1000;
        cyc();
        direction = 4'b0000;
        repeat (3) cyc();
        direction = 4'b1010;
        repeat (3) cyc();
        go_step(2'd2, 4'b1010, "hold_l");
        scan_check("hold_l_open", 5'd10, 12'h7C0);

        go_step(2'd1, 4'b0000, "die_at_1");
        die = 1'b1;
        cyc();
        die = 1'b0;
        check("die_state", {30'b0, state}, 32'd1);
        check("die_frame0", {29'b0, frame_idx}, 32'd0);
        dying = 1; prev = 0; order_bad = 0; dd_early = 0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (i == 10) respawn = 1'b1;
            else if (i == 20) die = 1'b1;
            cyc();
            respawn = 1'b0;
            die     = 1'b0;
            if (state == 2'b01) begin
                dying++;
                if (die_done) dd_early++;
                if (int'(frame_idx) != prev) begin
                    if (int'(frame_idx) != prev + 1) order_bad++;
                    prev = int'(frame_idx);
                end
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL dying_timeout: got=state%0d expected=state2", state);
        end
        check("dead_state", {30'b0, state}, 32'd2);
        check("dead_die_done", {31'b0, die_done}, 32'd1);
        check("dead_frame", {29'b0, frame_idx}, 32'd0);
        check("dying_cycles", 32'(dying), 32'd33);
        check("death_last_frame", 32'(prev), 32'd7);
        check("death_order", 32'(order_bad), 32'd0);
        check("die_done_early", 32'(dd_early), 32'd0);
        cyc();
        check("die_done_once", {31'b0, die_done}, 32'd0);
        scan_check("dead_row5", 5'd10, 12'h000);
        die = 1'b1;
        cyc();
        die = 1'b0;
        check("dead_ignores_die", {30'b0, state}, 32'd2);
        respawn = 1'b1;
        cyc();
        respawn = 1'b0;
        check("respawn_state", {30'b0, state}, 32'd0);
        check("respawn_frame", {29'b0, frame_idx}, 32'd0);

        die = 1'b1; respawn = 1'b1;
        cyc();
        die = 1'b0; respawn = 1'b0;
        check("die_beats_respawn", {30'b0, state}, 32'd1);
        x = 5'd2; y = 5'd10; in_valid = 1'b1;
        cyc();
        cyc();
        check("pre_reset_pipe", {30'b0, pixel, pix_valid}, 32'd3);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        check("midrst_state", {30'b0, state}, 32'd0);
        check("midrst_frame", {29'b0, frame_idx}, 32'd0);
        check("midrst_outs", {29'b0, pixel, pix_valid, die_done}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_release_valid", {31'b0, pix_valid}, 32'd0);
        go_step(2'd2, 4'b0000, "reset_head");
        scan_check("reset_head_r_open", 5'd10, 12'h03E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
